// File: rtl/fec_rx_pkg.sv
// Shared constants, types and helpers for the FEC frame receiver.
package fec_rx_pkg;

  localparam int unsigned K                = 4;
  localparam int unsigned NSTATES          = 8;
  localparam logic [3:0]  G0               = 4'hF;
  localparam logic [3:0]  G1               = 4'hD;
  localparam logic [15:0] CRC_POLY         = 16'h8005;
  localparam logic [15:0] CRC_INIT         = 16'hFFFF;
  localparam int unsigned DATA_W_DEFAULT   = 32;
  localparam int unsigned METRIC_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDecode,
    StCrc,
    StDone
  } rx_state_e;

  typedef logic [METRIC_W_DEFAULT-1:0] metric_t;

  // Encoder output {g1, g0} when bit u is shifted into encoder state st.
  function automatic logic [1:0] conv_out(input logic [2:0] st, input logic u);
    logic [3:0] r;
    r = {st, u};
    return {^(r & G1), ^(r & G0)};
  endfunction

  // One MSB-first step of the CRC-16 LFSR.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ d) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Combinational 8-state add-compare-select for the K=4 rate-1/2 code.
// Next state ns = {s[1:0], u}, so its predecessors are {0, ns[2:1]} and {1, ns[2:1]}.
module viterbi_acs import fec_rx_pkg::*; #(
  parameter int unsigned METRIC_W = METRIC_W_DEFAULT
) (
  input  logic [NSTATES-1:0][METRIC_W-1:0] metric_i,
  input  logic [1:0]                       pair_i,
  output logic [NSTATES-1:0][METRIC_W-1:0] metric_o,
  output logic [NSTATES-1:0]               decision_o
);

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

  // Saturating add keeps unreachable states pinned at the maximum metric.
  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0] b);
    logic [METRIC_W:0] sum;
    sum = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
    return sum[METRIC_W] ? {METRIC_W{1'b1}} : sum[METRIC_W-1:0];
  endfunction

  for (genvar g = 0; g < NSTATES; g++) begin : g_acs
    localparam logic [2:0] Ns = 3'(g);
    localparam logic [2:0] P0 = {1'b0, Ns[2:1]};
    localparam logic [2:0] P1 = {1'b1, Ns[2:1]};
    logic [METRIC_W-1:0] cand0, cand1;
    assign cand0 = sat_add(metric_i[P0], hamming(pair_i, conv_out(P0, Ns[0])));
    assign cand1 = sat_add(metric_i[P1], hamming(pair_i, conv_out(P1, Ns[0])));
    // Ties keep the lower-numbered predecessor.
    assign decision_o[g] = (cand1 < cand0);
    assign metric_o[g]   = decision_o[g] ? cand1 : cand0;
  end

endmodule

// File: rtl/fec_frame_receiver.sv
// Serial coded-frame receiver: capture, deinterleave, Viterbi decode, CRC-16 check.
// Define FEC_RX_DEINTERLEAVE_EN to undo the 4-byte dibit transpose before decoding.
module fec_frame_receiver import fec_rx_pkg::*; #(
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned METRIC_W = METRIC_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                crc_ok,
  output logic [METRIC_W-1:0] err_metric
);

  localparam int unsigned N    = DATA_W + 16;
  localparam int unsigned L    = 2 * N;
  localparam int unsigned CntW = $clog2(L + 1);
  localparam logic [NSTATES-1:0][METRIC_W-1:0] MetricInit =
      {{(NSTATES-1){{METRIC_W{1'b1}}}}, {METRIC_W{1'b0}}};

  rx_state_e                        state_q, state_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;
  logic [L-1:0]                     cap_q;
  logic [NSTATES-1:0][METRIC_W-1:0] metric_q, metric_new;
  logic [NSTATES-1:0][N-1:0]        path_q, path_new;
  logic [NSTATES-1:0]               decision;
  logic [15:0]                      crc_q, crc_next;
  logic [DATA_W-1:0]                out_data_q;
  logic                             crc_ok_q;
  logic [METRIC_W-1:0]              err_metric_q;

  logic accept, trellis_init, acs_en, crc_init, crc_en, finish;
  logic [L-1:0]          coded, coded_sh;
  logic [1:0]            rx_pair;
  logic [2:0]            best_state;
  logic [METRIC_W-1:0]   best_metric;
  logic [N-1:0]          win_path, win_sh;

`ifdef FEC_RX_DEINTERLEAVE_EN
  // Byte i dibit j of each 32-bit group comes from byte j dibit i.
  for (genvar g = 0; g < L / 32; g++) begin : g_grp
    for (genvar i = 0; i < 4; i++) begin : g_byte
      for (genvar j = 0; j < 4; j++) begin : g_pair
        assign coded[32*g + 8*i + 2*j +: 2] = cap_q[32*g + 8*j + 2*i +: 2];
      end
    end
  end
`else
  assign coded = cap_q;
`endif

  // Pair k sits at the top of the vector after shifting left by 2k.
  assign coded_sh = coded << {cnt_q, 1'b0};
  assign rx_pair  = coded_sh[L-1 -: 2];

  viterbi_acs #(
    .METRIC_W(METRIC_W)
  ) u_acs (
    .metric_i  (metric_q),
    .pair_i    (rx_pair),
    .metric_o  (metric_new),
    .decision_o(decision)
  );

  // Register exchange: each state inherits its chosen predecessor's path plus its own input bit.
  for (genvar g = 0; g < NSTATES; g++) begin : g_surv
    localparam logic [2:0] Ns = 3'(g);
    assign path_new[g] = {path_q[{decision[g], Ns[2:1]}][N-2:0], Ns[0]};
  end

  // Minimum-metric survivor, lowest state index on ties.
  always_comb begin
    best_state  = 3'd0;
    best_metric = metric_q[0];
    for (int s = 1; s < NSTATES; s++) begin
      if (metric_q[s] < best_metric) begin
        best_metric = metric_q[s];
        best_state  = 3'(s);
      end
    end
  end

  assign win_path = path_q[best_state];
  assign win_sh   = win_path << cnt_q;
  assign crc_next = crc16_step(crc_q, win_sh[N-1]);

  // FSM next state, counter and datapath enables.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    trellis_init = 1'b0;
    acs_en       = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    finish       = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StLoad;
          cnt_d   = CntW'(1);
        end
      end
      StLoad: begin
        if (in_valid) begin
          accept = 1'b1;
          if (cnt_q == CntW'(L - 1)) begin
            state_d      = StDecode;
            cnt_d        = '0;
            trellis_init = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDecode: begin
        acs_en = 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          state_d  = StCrc;
          cnt_d    = '0;
          crc_init = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCrc: begin
        crc_en = 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture shift register, trellis state, CRC LFSR and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q        <= '0;
      metric_q     <= '0;
      path_q       <= '0;
      crc_q        <= '0;
      out_data_q   <= '0;
      crc_ok_q     <= 1'b0;
      err_metric_q <= '0;
    end else begin
      if (accept) cap_q <= {cap_q[L-2:0], in_data};
      if (trellis_init) begin
        metric_q <= MetricInit;
        path_q   <= '0;
      end else if (acs_en) begin
        metric_q <= metric_new;
        path_q   <= path_new;
      end
      if (crc_init)    crc_q <= CRC_INIT;
      else if (crc_en) crc_q <= crc_next;
      // Last CRC step: latch results so they are visible while in DONE.
      if (finish) begin
        out_data_q   <= win_path[N-1 -: DATA_W];
        crc_ok_q     <= (crc_next == win_path[15:0]);
        err_metric_q <= best_metric;
      end
    end
  end

  assign in_ready   = (state_q == StIdle) || (state_q == StLoad);
  assign out_valid  = (state_q == StDone);
  assign out_data   = out_data_q;
  assign crc_ok     = crc_ok_q;
  assign err_metric = err_metric_q;

endmodule

// File: tb/tb_fec_frame_receiver.sv
// Scoreboard bench for fec_frame_receiver; frames come from a transmitter model.
module tb_fec_frame_receiver;

  localparam int DW = 32;
  localparam int N  = DW + 16;
  localparam int L  = 2 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          crc_ok;
  logic [7:0]    err_metric;

  fec_frame_receiver #(
    .DATA_W  (DW),
    .METRIC_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .crc_ok    (crc_ok),
    .err_metric(err_metric)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        ok;
    logic [7:0]  metric;
    logic [31:0] when;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: CRC-16 over data, then K=4 convolutional encode.
  function automatic logic [15:0] crc16(input logic [31:0] d);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  function automatic logic [L-1:0] encode(input logic [31:0] d);
    logic [N-1:0] u;
    logic [2:0]   r;
    logic [3:0]   r4;
    logic [L-1:0] c;
    u = {d, crc16(d)};
    r = 3'd0;
    c = '0;
    for (int k = 0; k < N; k++) begin
      r4 = {r, u[N-1-k]};
      c[L-1-2*k] = r4[3] ^ r4[2] ^ r4[0];
      c[L-2-2*k] = ^r4;
      r = r4[2:0];
    end
    return c;
  endfunction

  function automatic logic [L-1:0] interleave(input logic [L-1:0] c);
    logic [L-1:0] t;
    t = '0;
    for (int g = 0; g < L / 32; g++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          t[32*g + 8*i + 2*j +: 2] = c[32*g + 8*j + 2*i +: 2];
    return t;
  endfunction

  function automatic logic [L-1:0] tx_frame(input logic [31:0] d);
`ifdef FEC_RX_DEINTERLEAVE_EN
    return interleave(encode(d));
`else
    return encode(d);
`endif
  endfunction

  // Wait (bounded) for in_ready, optionally driving junk bits that must be ignored.
  task automatic wait_ready(input bit noise, output int n);
    n = 0;
    while (!in_ready && n < 400) begin
      if (noise) begin
        in_valid = 1'b1;
        in_data  = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    end
  endtask

  task automatic send_bits(input logic [L-1:0] tx, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      in_valid = 1'b1;
      in_data  = tx[L-1-b];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Send a full frame and post the expected result; out_valid is due 80 edges later.
  task automatic send_frame(input logic [L-1:0] tx, input logic [31:0] d, input logic ok,
                            input logic [7:0] m);
    exp_t e;
    send_bits(tx, L);
    e.data   = d;
    e.ok     = ok;
    e.metric = m;
    e.when   = cyc + 80;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_crc_ok"}, 64'(crc_ok), 64'(0));
    check({tag, "_err_metric"}, 64'(err_metric), 64'(0));
  endtask

  // Monitor: pop and compare whenever a result strobe appears.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid: got out_data %0h, expected no result", out_data);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(mon_e.data));
        check("crc_ok", 64'(crc_ok), 64'(mon_e.ok));
        check("err_metric", 64'(err_metric), 64'(mon_e.metric));
        check("out_valid_cycle", 64'(cyc), 64'(mon_e.when));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [L-1:0] tx;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Clean frame
    wait_ready(1'b0, n);
    send_frame(tx_frame(32'hDEADBEEF), 32'hDEADBEEF, 1'b1, 8'd0);

    // Same frame with two coded bits flipped, sent back to back
    tx = tx_frame(32'hDEADBEEF);
    tx[10] = ~tx[10];
    tx[60] = ~tx[60];
    wait_ready(1'b0, n);
    check("busy_cycles_1", 64'(n), 64'(81));
    send_frame(tx, 32'hDEADBEEF, 1'b1, 8'd2);

    // Partial frame aborted by reset, then a full frame
    wait_ready(1'b0, n);
    check("busy_cycles_2", 64'(n), 64'(81));
    send_bits(tx_frame(32'h12345678), 50);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    wait_ready(1'b0, n);
    send_frame(tx_frame(32'h12345678), 32'h12345678, 1'b1, 8'd0);

    // All-zero input decodes to zero with a bad CRC
    wait_ready(1'b0, n);
    check("busy_cycles_3", 64'(n), 64'(81));
    send_frame('0, 32'h0, 1'b0, 8'd0);

    // Junk bits while busy must not disturb the next frame
    wait_ready(1'b1, n);
    check("busy_cycles_noise", 64'(n), 64'(81));
    send_frame(tx_frame(32'hCAFEF00D), 32'hCAFEF00D, 1'b1, 8'd0);

    wait_ready(1'b1, n);
    check("busy_cycles_noise2", 64'(n), 64'(81));
    send_frame(tx_frame(32'hA5A5A5A5), 32'hA5A5A5A5, 1'b1, 8'd0);

    wait_ready(1'b0, n);
    check("busy_cycles_last", 64'(n), 64'(81));
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
